// File: rtl/seq_gen_if.sv
// Output stream of the sequence generator: valid/ready beats carrying one entry each.
interface seq_gen_if #(
    parameter int DATA_W = 4
);
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, out_data, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/seq_gen.sv
// Programmable sequence generator: replays a writable entry table over a valid/ready
// stream, ascending or descending, in wrap or one-shot mode.
module seq_gen #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH),
    parameter int LW     = $clog2(DEPTH) + 1,
    parameter logic [DEPTH*DATA_W-1:0] INIT_SEQ = 32'h1030_7102
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic              dir,
    input  logic [LW-1:0]     len,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    seq_gen_if.master         os,
    output logic              busy,
    output logic              done,
    output logic              wr_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                   state;
    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [AW-1:0]                ptr;
    logic [LW-1:0]                len_q;
    logic [LW-1:0]                len_eff;
    logic                         mode_q;
    logic                         dir_q;
    logic                         run;
    logic                         hs;
    logic                         last;
    logic                         addr_oob;
    logic                         wr_bad;
    logic                         wr_ok;

    assign run          = (state == S_RUN);
    assign busy         = run;
    assign hs           = run & os.out_ready;
    assign last         = dir_q ? (ptr == '0) : (LW'(ptr) == len_q - LW'(1));
    assign os.out_valid = run;
    assign os.out_data  = mem[ptr];
    assign os.out_last  = run & last;

    // Zero or oversized lengths mean "whole table".
    assign len_eff = (len == '0 || len > LW'(DEPTH)) ? LW'(DEPTH) : len;

    // Only a non-power-of-two table can be addressed past its end.
    if ((1 << AW) == DEPTH) begin : g_p2
        assign addr_oob = 1'b0;
    end else begin : g_np2
        assign addr_oob = ({1'b0, wr_addr} >= LW'(DEPTH));
    end

    assign wr_bad = wr_en & (run | addr_oob);
    assign wr_ok  = wr_en & ~wr_bad;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem    <= INIT_SEQ;
            state  <= S_IDLE;
            ptr    <= '0;
            len_q  <= LW'(DEPTH);
            mode_q <= 1'b0;
            dir_q  <= 1'b0;
            done   <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            done   <= 1'b0;
            wr_err <= wr_bad;
            if (wr_ok) mem[wr_addr] <= wr_data;

            if (stop) begin
                state <= S_IDLE;
                ptr   <= '0;
            end else if (start && !run) begin
                state  <= S_RUN;
                mode_q <= mode;
                dir_q  <= dir;
                len_q  <= len_eff;
                ptr    <= dir ? AW'(len_eff - LW'(1)) : '0;
            end else if (hs) begin
                if (last) begin
                    // Wrap restarts the pass with no bubble; one-shot parks in DONE.
                    if (mode_q) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        ptr <= dir_q ? AW'(len_q - LW'(1)) : '0;
                    end
                end else begin
                    ptr <= dir_q ? ptr - AW'(1) : ptr + AW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_gen.sv
// Table-driven bench for seq_gen with a scoreboard of expected beats built from a table model.
module tb_seq_gen;
    logic       clk;
    logic       n_rst;
    logic       start, stop, mode, dir;
    logic [3:0] len;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       busy, done, wr_err;

    seq_gen_if #(.DATA_W(4)) sif ();

    seq_gen dut (
        .clk(clk), .n_rst(n_rst), .start(start), .stop(stop), .mode(mode), .dir(dir),
        .len(len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .os(sif),
        .busy(busy), .done(done), .wr_err(wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       mode;
        bit       dir;
        bit [3:0] len;
        int       beats;
        bit [3:0] rdy;
        bit       wr;
        bit [2:0] wa;
        bit [3:0] wd;
        bit       poke;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        bit         last;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mdl[8];
    int         checks   = 0;
    int         failures = 0;
    vec_t       vt[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mdl_reset();
        logic [31:0] init;
        init = 32'h1030_7102;
        for (int i = 0; i < 8; i++) mdl[i] = init[i*4 +: 4];
    endtask

    task automatic wr(input int a, input int d, input bit expect_err);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = 4'(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        chk("wr_err_pulse", int'(wr_err), int'(expect_err));
        if (expect_err) begin
            @(negedge clk);
            chk("wr_err_clear", int'(wr_err), 0);
        end else begin
            mdl[3'(a)] = 4'(d);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   L, n, cyc, k, idx;
        exp_t e;
        L = (v.len == 0 || v.len > 8) ? 8 : int'(v.len);
        @(posedge clk); #1;
        start = 1'b1; mode = v.mode; dir = v.dir; len = v.len;
        wr_en = v.wr; wr_addr = v.wa; wr_data = v.wd;
        if (v.wr) mdl[v.wa] = v.wd;
        for (int b = 0; b < v.beats; b++) begin
            k      = b % L;
            idx    = v.dir ? L - 1 - k : k;
            e.data = mdl[3'(idx)];
            e.last = (k == L - 1);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0; mode = 1'b0; dir = 1'b0; len = 4'd0;
        n = 0; cyc = 0;
        while (n < v.beats && cyc < 100) begin
            sif.out_ready = v.rdy[2'(cyc)];
            if (v.poke && cyc == 1) begin
                start = 1'b1; mode = ~v.mode; dir = ~v.dir; len = 4'd2;
            end
            @(negedge clk);
            chk({tag, "_valid"}, int'(sif.out_valid), 1);
            if (sb.size() > 0) begin
                e = sb[0];
                chk({tag, "_data"}, int'(sif.out_data), int'(e.data));
                chk({tag, "_last"}, int'(sif.out_last), int'(e.last));
                if (sif.out_ready) begin
                    void'(sb.pop_front());
                    n++;
                end
            end
            @(posedge clk); #1;
            start = 1'b0; mode = 1'b0; dir = 1'b0; len = 4'd0;
            cyc++;
        end
        if (n < v.beats) begin
            chk({tag, "_timeout"}, n, v.beats);
            sb.delete();
        end
        sif.out_ready = 1'b0;
        if (v.mode && v.beats == L) begin
            @(negedge clk);
            chk({tag, "_end_valid"}, int'(sif.out_valid), 0);
            chk({tag, "_done"}, int'(done), 1);
            chk({tag, "_end_busy"}, int'(busy), 0);
            @(negedge clk);
            chk({tag, "_done_once"}, int'(done), 0);
        end else begin
            stop = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0;
            @(negedge clk);
            chk({tag, "_stop_valid"}, int'(sif.out_valid), 0);
            chk({tag, "_stop_busy"}, int'(busy), 0);
            chk({tag, "_stop_done"}, int'(done), 0);
            @(negedge clk);
            chk({tag, "_stop_done2"}, int'(done), 0);
        end
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; dir = 1'b0; len = 4'd0;
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0; sif.out_ready = 1'b0;
        mdl_reset();

        //         mode dir len beats rdy      wr wa wd poke
        vt[0] = '{1'b0, 1'b0, 4'd8, 10, 4'b1111, 1'b0, 3'd0, 4'd0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 4'd8, 12, 4'b1001, 1'b0, 3'd0, 4'd0, 1'b0};
        vt[2] = '{1'b1, 1'b1, 4'd4,  4, 4'b1111, 1'b0, 3'd0, 4'd0, 1'b1};
        vt[3] = '{1'b0, 1'b0, 4'd0, 10, 4'b1111, 1'b0, 3'd0, 4'd0, 1'b0};
        vt[4] = '{1'b0, 1'b0, 4'd9, 10, 4'b1111, 1'b0, 3'd0, 4'd0, 1'b0};
        vt[5] = '{1'b0, 1'b0, 4'd1,  3, 4'b1111, 1'b0, 3'd0, 4'd0, 1'b0};
        vt[6] = '{1'b0, 1'b1, 4'd3,  5, 4'b1101, 1'b0, 3'd0, 4'd0, 1'b0};
        vt[7] = '{1'b1, 1'b0, 4'd8,  3, 4'b1111, 1'b0, 3'd0, 4'd0, 1'b0};
        vt[8] = '{1'b1, 1'b0, 4'd8,  8, 4'b0110, 1'b0, 3'd0, 4'd0, 1'b0};

        #12;
        chk("rst_valid", int'(sif.out_valid), 0);
        chk("rst_last", int'(sif.out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr_err", int'(wr_err), 0);
        chk("rst_data", int'(sif.out_data), 2);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Load in IDLE, then a short ascending one-shot shows the new entry.
        wr(3, 9, 1'b0);
        run_vec('{1'b1, 1'b0, 4'd4, 4, 4'b1111, 1'b0, 3'd0, 4'd0, 1'b0}, "load");
        // Write landing in the same cycle as start.
        run_vec('{1'b1, 1'b0, 4'd2, 2, 4'b1111, 1'b1, 3'd0, 4'd5, 1'b0}, "wr_start");

        // Write during RUN is rejected and leaves the table untouched.
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; dir = 1'b0; len = 4'd8;
        @(posedge clk); #1;
        start = 1'b0; len = 4'd0;
        wr(5, 12, 1'b1);
        chk("run_busy", int'(busy), 1);
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        run_vec('{1'b1, 1'b0, 4'd8, 8, 4'b1111, 1'b0, 3'd0, 4'd0, 1'b0}, "after_rej");

        // Asynchronous reset mid-run discards loaded values.
        wr(1, 9, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; dir = 1'b0; len = 4'd8;
        @(posedge clk); #1;
        start = 1'b0; len = 4'd0; sif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 n_rst = 1'b0;
        #1;
        chk("mid_rst_valid", int'(sif.out_valid), 0);
        chk("mid_rst_last", int'(sif.out_last), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_wr_err", int'(wr_err), 0);
        chk("mid_rst_data", int'(sif.out_data), 2);
        sif.out_ready = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        mdl_reset();
        run_vec('{1'b1, 1'b0, 4'd8, 8, 4'b1111, 1'b0, 3'd0, 4'd0, 1'b0}, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
Parametrised programmable sequence generator. It replays a stored list of DATA_W-bit values over a valid/ready stream and feeds digit/pattern consumers downstream, such as display and stimulus paths. The list is loaded through a register-style write port and preset at reset to a default pattern. Sequence length, direction and wrap/one-shot mode are selected per run.

Parameters:
DATA_W, 4, width of each sequence entry.
DEPTH, 8, number of storage entries (>=2).
AW, $clog2(DEPTH), entry address width (derived; do not override).
LW, $clog2(DEPTH)+1, length field width (derived).
INIT_SEQ, 32'h1030_7102, DEPTH*DATA_W reset contents. Entry i is bits [i*DATA_W +: DATA_W]. The default gives entries 0..7 = 2,0,1,7,0,3,0,1.

Ports:
clk  in  1  clock, all logic rising-edge.
n_rst  in  1  asynchronous active-low reset.
start  in  1  begin a run (sampled only in IDLE or DONE).
stop  in  1  abort run, return to IDLE.
mode  in  1  0 = wrap continuously, 1 = one-shot; sampled at start.
dir  in  1  0 = ascending, 1 = descending; sampled at start.
len  in  LW  entries per pass; sampled at start.
wr_en  in  1  write strobe.
wr_addr  in  AW  write entry index.
wr_data  in  DATA_W  write value.
out_valid  out  1  out_data is valid.
out_ready  in  1  consumer accepts.
out_data  out  DATA_W  current entry value.
out_last  out  1  current entry is the final one of a pass.
busy  out  1  state == RUN.
done  out  1  one-cycle pulse when a one-shot run completes.
wr_err  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (async, n_rst=0):
  - mem <= INIT_SEQ; state IDLE; ptr 0; len_q DEPTH; mode_q 0; dir_q 0.
  - out_valid, out_last, busy, done, wr_err all 0.
  - out_data = mem[0].
- States: IDLE, RUN, DONE. Priority each cycle: stop > start > handshake.
- IDLE/DONE with start=1:
  - Capture mode, dir and len. len of 0 or >DEPTH is clamped to DEPTH.
  - ptr <= 0 if dir=0, else len_q-1.
  - Go to RUN next cycle.
- RUN: out_valid=1, out_data=mem[ptr] combinationally from registered storage.
  - out_last = (ptr==len_q-1) for dir=0, (ptr==0) for dir=1.
  - Handshake = out_valid & out_ready. ptr advances only on a handshake. With out_ready held high, one entry is emitted per cycle.
  - Without a handshake, out_data and ptr hold stable (standard valid/ready; out_valid never drops without acceptance except on stop/reset).
  - Handshake on the out_last entry:
    - mode_q=0: ptr wraps to the first entry (0 or len_q-1) with no bubble.
    - mode_q=1: go to DONE, done pulses the following cycle, out_valid=0.
- DONE: out_valid=0. Holds until start, which re-arms exactly as from IDLE.
- stop=1 in any state: next cycle state IDLE, ptr 0, out_valid 0, no done pulse. Any pending beat is dropped.
- start while in RUN is ignored; captured config is unchanged.
- Writes:
  - Accepted in IDLE/DONE: mem[wr_addr] <= wr_data, visible the next cycle.
  - In RUN: ignored, wr_err=1 next cycle for one cycle.
  - wr_addr >= DEPTH (non-power-of-2 DEPTH): ignored, wr_err pulses.
  - Write and start in the same cycle: write lands; the run starts with updated contents.
- len_q=1: a single entry, out_last permanently 1; in wrap mode the same value repeats.
- Mid-operation reset restores INIT_SEQ contents; loaded values are lost.

Test Plan:
- Reset, start (mode=0, dir=0, len=8), out_ready=1 -> out_data 2,0,1,7,0,3,0,1,2,0,... one per cycle; out_last on every 8th beat.
- Same run, out_ready toggled 1,0,0,1 -> out_data stays stable while not ready; no entry skipped or duplicated.
- start mode=1, dir=1, len=4 -> out_data 7,1,0,2, out_last on 2; out_valid then 0, done pulses once, busy 0.
- len=0 and len=9 -> both behave as 8; wrap sequence identical to the first scenario.
- Write addr3=9 in IDLE, then start len=4 -> 2,0,1,9. Write during RUN -> wr_err pulse, contents unchanged.
- Stop mid-run at beat 3 -> out_valid 0 next cycle, done stays 0. Assert n_rst mid-run after loading a 9 -> contents return to defaults, all outputs 0.
